// File: rtl/mul_arbiter.sv
// mul_arbiter
// Round-robin controller sharing one registered multiplier stage among four
// requesters. A winner is picked in IDLE, its operand pair is latched into the
// multiplier operand buffer, the fixed multiplier latency is counted down in
// WAIT, and the product is returned tagged with the requester index in RESP.
// Only one operation is in flight at a time.
//
// Parameters:
//   Size    - operand / product width in bits
//   Latency - cycles from mul_start high to mul_p valid (legal range 1..15)
//
// Ports:
//   clk        - clock, rising edge
//   rst_async  - asynchronous active-high reset
//   req        - request per requester, bit i = requester i
//   a_in/b_in  - operands; requester i drives bits [i*Size +: Size]
//   gnt        - one-hot pulse: operands of requester i captured
//   mul_d1/d2  - registered operands to the shared multiplier
//   mul_start  - pulse: mul_d1/mul_d2 newly valid
//   mul_p      - product from the shared multiplier
//   res        - returned product (held until the next result)
//   res_id     - index of the requester owning res
//   res_valid  - pulse: res/res_id valid
//   busy       - high whenever the controller is not in IDLE
module mul_arbiter #(
  parameter int Size    = 8,
  parameter int Latency = 2
) (
  input  logic              clk,
  input  logic              rst_async,
  input  logic [3:0]        req,
  input  logic [4*Size-1:0] a_in,
  input  logic [4*Size-1:0] b_in,
  output logic [3:0]        gnt,
  output logic [Size-1:0]   mul_d1,
  output logic [Size-1:0]   mul_d2,
  output logic              mul_start,
  input  logic [Size-1:0]   mul_p,
  output logic [Size-1:0]   res,
  output logic [1:0]        res_id,
  output logic              res_valid,
  output logic              busy
);

  // Latency is at most 15, so four bits of down-counter suffice.
  localparam int CntW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [1:0]        ptr, ptr_nxt;
  logic [1:0]        id_reg, id_nxt;
  logic [CntW-1:0]   cnt, cnt_nxt;
  logic [3:0]        gnt_nxt;
  logic [Size-1:0]   mul_d1_nxt, mul_d2_nxt, res_nxt;
  logic [1:0]        res_id_nxt;
  logic              mul_start_nxt, res_valid_nxt, busy_nxt;

  // Round-robin winner: first set request bit scanning ptr, ptr+1, ... mod 4.
  // The 2-bit scan index wraps naturally.
  logic       win_found;
  logic [1:0] win;
  logic [1:0] scan;

  always_comb begin
    win_found = 1'b0;
    win       = '0;
    scan      = '0;
    for (int k = 0; k < 4; k++) begin
      scan = ptr + 2'(k);
      if (!win_found && req[scan]) begin
        win_found = 1'b1;
        win       = scan;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    // NOTE: every signal gets a default before the case statement so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    state_nxt     = state;
    ptr_nxt       = ptr;
    id_nxt        = id_reg;
    cnt_nxt       = cnt;
    mul_d1_nxt    = mul_d1;
    mul_d2_nxt    = mul_d2;
    res_nxt       = res;
    res_id_nxt    = res_id;
    gnt_nxt       = '0;
    mul_start_nxt = 1'b0;
    res_valid_nxt = 1'b0;

    unique case (state)
      IDLE: begin
        if (win_found) begin
          mul_d1_nxt    = a_in[int'(win)*Size +: Size];
          mul_d2_nxt    = b_in[int'(win)*Size +: Size];
          gnt_nxt       = 4'(1) << win;
          mul_start_nxt = 1'b1;
          id_nxt        = win;
          ptr_nxt       = win + 2'd1;
          cnt_nxt       = CntW'(Latency);
          state_nxt     = WAIT;
        end
      end
      WAIT: begin
        // gnt/mul_start fall back to their zero defaults after the first
        // WAIT cycle; the product is sampled when the count reaches one.
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          res_nxt       = mul_p;
          res_id_nxt    = id_reg;
          res_valid_nxt = 1'b1;
          state_nxt     = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state     <= IDLE;
      ptr       <= '0;
      id_reg    <= '0;
      cnt       <= '0;
      gnt       <= '0;
      mul_d1    <= '0;
      mul_d2    <= '0;
      mul_start <= 1'b0;
      res       <= '0;
      res_id    <= '0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      id_reg    <= id_nxt;
      cnt       <= cnt_nxt;
      gnt       <= gnt_nxt;
      mul_d1    <= mul_d1_nxt;
      mul_d2    <= mul_d2_nxt;
      mul_start <= mul_start_nxt;
      res       <= res_nxt;
      res_id    <= res_id_nxt;
      res_valid <= res_valid_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter
// Three instances (Latency 2, 1 and 5) share one stimulus stream. Each has a
// transaction-level reference model that schedules grant, result and busy
// windows from the round-robin rules and compares every output each cycle.
module tb_mul_arbiter;

  localparam int Size  = 8;
  localparam int NInst = 3;

  logic              clk = 1'b0;
  logic              rst_async;
  logic [3:0]        req;
  logic [4*Size-1:0] a_in, b_in;

  logic [3:0]      gnt_o   [NInst];
  logic [Size-1:0] d1_o    [NInst];
  logic [Size-1:0] d2_o    [NInst];
  logic [Size-1:0] p_o     [NInst];
  logic [Size-1:0] res_o   [NInst];
  logic [1:0]      id_o    [NInst];
  logic            start_o [NInst];
  logic            rv_o    [NInst];
  logic            busy_o  [NInst];

  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < NInst; g++) begin : inst
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 5);

    // Shared multiplier stand-in: product of the buffered operands.
    assign p_o[g] = Size'(d1_o[g] * d2_o[g]);

    mul_arbiter #(.Size(Size), .Latency(L)) dut (
      .clk       (clk),
      .rst_async (rst_async),
      .req       (req),
      .a_in      (a_in),
      .b_in      (b_in),
      .gnt       (gnt_o[g]),
      .mul_d1    (d1_o[g]),
      .mul_d2    (d2_o[g]),
      .mul_start (start_o[g]),
      .mul_p     (p_o[g]),
      .res       (res_o[g]),
      .res_id    (id_o[g]),
      .res_valid (rv_o[g]),
      .busy      (busy_o[g])
    );

    // Model: pointer, next cycle a decision may be taken, scheduled grant and
    // result cycles, and the values visible once those cycles arrive.
    int              m_ptr, m_next, gnt_at, res_at, m_w;
    logic [1:0]      m_win, m_id, p_id;
    logic [Size-1:0] m_d1, m_d2, m_res, p_d1, p_d2, p_res;

    always @(negedge clk) begin
      if (rst_async) begin
        m_ptr = 0; m_next = 0; gnt_at = -1; res_at = -1;
        m_win = '0; m_id = '0; m_d1 = '0; m_d2 = '0; m_res = '0;
        check($sformatf("L%0d rst gnt", L),   32'(gnt_o[g]),   32'h0);
        check($sformatf("L%0d rst start", L), 32'(start_o[g]), 32'h0);
        check($sformatf("L%0d rst rv", L),    32'(rv_o[g]),    32'h0);
        check($sformatf("L%0d rst busy", L),  32'(busy_o[g]),  32'h0);
        check($sformatf("L%0d rst res", L),   32'(res_o[g]),   32'h0);
        check($sformatf("L%0d rst d1", L),    32'(d1_o[g]),    32'h0);
      end else begin
        if (cyc == gnt_at) begin m_d1 = p_d1; m_d2 = p_d2; end
        if (cyc == res_at) begin m_res = p_res; m_id = p_id; end

        check($sformatf("L%0d gnt", L),   32'(gnt_o[g]),
              (cyc == gnt_at) ? (32'h1 << m_win) : 32'h0);
        check($sformatf("L%0d start", L), 32'(start_o[g]), 32'(cyc == gnt_at));
        check($sformatf("L%0d rv", L),    32'(rv_o[g]),    32'(cyc == res_at));
        check($sformatf("L%0d busy", L),  32'(busy_o[g]),
              32'(gnt_at >= 0 && cyc >= gnt_at && cyc <= res_at));
        check($sformatf("L%0d d1", L),    32'(d1_o[g]),    32'(m_d1));
        check($sformatf("L%0d d2", L),    32'(d2_o[g]),    32'(m_d2));
        check($sformatf("L%0d res", L),   32'(res_o[g]),   32'(m_res));
        check($sformatf("L%0d res_id", L), 32'(id_o[g]),   32'(m_id));

        if (cyc >= m_next && req != 4'b0) begin
          m_w = -1;
          for (int k = 0; k < 4; k++)
            if (m_w < 0 && req[(m_ptr + k) % 4]) m_w = (m_ptr + k) % 4;
          m_win  = 2'(m_w);
          p_id   = 2'(m_w);
          p_d1   = a_in[m_w*Size +: Size];
          p_d2   = b_in[m_w*Size +: Size];
          p_res  = Size'((int'(p_d1) * int'(p_d2)) % (1 << Size));
          gnt_at = cyc + 1;
          res_at = cyc + 1 + L;
          m_next = cyc + L + 2;
          m_ptr  = (m_w + 1) % 4;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [Size-1:0] a, input logic [Size-1:0] b);
    a_in[i*Size +: Size] = a;
    b_in[i*Size +: Size] = b;
  endtask

  // Asserts reset between edges and checks that outputs clear immediately.
  task automatic do_reset();
    rst_async = 1'b1;
    #1;
    for (int i = 0; i < NInst; i++) begin
      check("async gnt",   32'(gnt_o[i]),   32'h0);
      check("async start", 32'(start_o[i]), 32'h0);
      check("async rv",    32'(rv_o[i]),    32'h0);
      check("async busy",  32'(busy_o[i]),  32'h0);
      check("async d1",    32'(d1_o[i]),    32'h0);
      check("async res",   32'(res_o[i]),   32'h0);
    end
    step(2);
    rst_async = 1'b0;
  endtask

  initial begin
    rst_async = 1'b1;
    req  = '0;
    a_in = '0;
    b_in = '0;
    step(3);
    rst_async = 1'b0;
    step(2);

    // Single request: 3*5 = 15 for requester 0.
    set_ops(0, 8'd3, 8'd5);
    req = 4'b0001; step(1); req = '0; step(10);

    // Round-robin with all requesters held high.
    do_reset();
    set_ops(0, 8'd2, 8'd3); set_ops(1, 8'd4, 8'd5);
    set_ops(2, 8'd6, 8'd7); set_ops(3, 8'd1, 8'd9);
    req = 4'b1111; step(32); req = '0; step(10);

    // Pointer wrap: requester 3 first, then 0 and 3 competing.
    do_reset();
    req = 4'b1000; step(1); req = 4'b1001; step(20); req = '0; step(10);

    // Late request raised while requester 1 is being served.
    do_reset();
    req = 4'b0010; step(1); req = '0; step(1);
    req = 4'b0100; step(12); req = '0; step(10);

    // Reset in the second WAIT cycle of the Latency-2 instance.
    do_reset();
    req = 4'b0001; step(1); req = '0; step(1);
    do_reset();
    req = 4'b0010; step(1); req = '0; step(10);

    // Latency sweep operands: 10*12 = 120.
    set_ops(0, 8'd10, 8'd12);
    req = 4'b0001; step(1); req = '0; step(12);

    // Randomized traffic with occasional reset pulses.
    for (int n = 0; n < 600; n++) begin
      rst_async = ($urandom_range(0, 99) == 0);
      req  = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0;
      a_in = $urandom;
      b_in = $urandom;
      step(1);
    end
    rst_async = 1'b0;
    req = '0;
    step(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
